// File: rtl/sipo_deframer.sv
// sipo_deframer
// ---------------------------------------------------------------------------
// Serial-in / parallel-out deframer. It hunts the strobed bit stream for a
// WIDTH-bit sync word. After a match it assembles FRAME_WORDS payload words,
// first bit received = MSB, and presents each word on a valid/ready output
// register. When the last word of a frame commits, the block returns to
// hunting with a cleared history.
//
// Optional feature: define DEFRAMER_PARITY_EN to expect one even-parity bit
// after every payload word. The word commits on the parity-bit edge, and
// parity_err pulses on a mismatch. The word is still delivered in that case.
//
// Ports
//   clk         : clock, all state changes on posedge
//   rst         : synchronous active-high reset
//   sin         : serial data bit
//   sin_en      : bit strobe, sin is sampled only when high
//   dout        : assembled payload word
//   dout_valid  : dout holds an unconsumed word
//   dout_ready  : consumer accepts dout on an edge with dout_valid=1
//   frame_start : one-cycle pulse after the sync word is matched
//   frame_end   : one-cycle pulse with the commit of the frame's last word
//   overflow    : sticky, set when a completed word had to be dropped
//   parity_err  : one-cycle parity mismatch pulse (0 without parity build)
//   in_frame    : high while a frame payload is being received
// ---------------------------------------------------------------------------
module sipo_deframer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int               FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_start,
    output logic             frame_end,
    output logic             overflow,
    output logic             parity_err,
    output logic             in_frame
);

    localparam int BCW = $clog2(WIDTH + 1);

`ifdef DEFRAMER_PARITY_EN
    typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_HUNT, S_PAYLOAD} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] hunt, hunt_n, hunt_shift;
    logic [BCW-1:0]   hunt_cnt, hunt_cnt_n;   // strobed bits of history, saturates at WIDTH
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic [7:0]       word_cnt, word_cnt_n;
    logic [WIDTH-1:0] dout_n;
    logic             dout_valid_n, frame_start_n, frame_end_n, overflow_n;
    logic             commit;
    logic [WIDTH-1:0] commit_word;
`ifdef DEFRAMER_PARITY_EN
    logic             parity_err_n;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HUNT;
            hunt        <= '0;
            hunt_cnt    <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            hunt        <= hunt_n;
            hunt_cnt    <= hunt_cnt_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            word_cnt    <= word_cnt_n;
            dout        <= dout_n;
            dout_valid  <= dout_valid_n;
            frame_start <= frame_start_n;
            frame_end   <= frame_end_n;
            overflow    <= overflow_n;
        end
    end

`ifdef DEFRAMER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= parity_err_n;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign in_frame = (state != S_HUNT);

    // Next-state, datapath and handshake
    always_comb begin
        state_n       = state;
        hunt_n        = hunt;
        hunt_cnt_n    = hunt_cnt;
        shreg_n       = shreg;
        bit_cnt_n     = bit_cnt;
        word_cnt_n    = word_cnt;
        dout_n        = dout;
        dout_valid_n  = dout_valid;
        frame_start_n = 1'b0;
        frame_end_n   = 1'b0;
        overflow_n    = overflow;
        commit        = 1'b0;
        commit_word   = '0;
        hunt_shift    = (hunt << 1) | {{(WIDTH-1){1'b0}}, sin};
`ifdef DEFRAMER_PARITY_EN
        parity_err_n  = 1'b0;
`endif

        case (state)
            S_HUNT: begin
                if (sin_en) begin
                    hunt_n = hunt_shift;
                    if (hunt_cnt != BCW'(WIDTH))
                        hunt_cnt_n = hunt_cnt + 1'b1;
                    // This bit completes at least WIDTH bits of history.
                    // Leading zeros from reset must not take part in a match.
                    if (hunt_shift == SYNC_WORD && hunt_cnt >= BCW'(WIDTH - 1)) begin
                        state_n       = S_PAYLOAD;
                        frame_start_n = 1'b1;
                        bit_cnt_n     = '0;
                        word_cnt_n    = '0;
                        shreg_n       = '0;
                    end
                end
            end
            S_PAYLOAD: begin
                if (sin_en) begin
                    shreg_n = (shreg << 1) | {{(WIDTH-1){1'b0}}, sin};
                    if (bit_cnt == BCW'(WIDTH - 1)) begin
                        bit_cnt_n = '0;
`ifdef DEFRAMER_PARITY_EN
                        state_n   = S_PARITY;
`else
                        commit      = 1'b1;
                        commit_word = shreg_n;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef DEFRAMER_PARITY_EN
            S_PARITY: begin
                if (sin_en) begin
                    commit       = 1'b1;
                    commit_word  = shreg;
                    // Even parity: data bits plus the parity bit hold an even number of ones.
                    parity_err_n = (^shreg) ^ sin;
                    state_n      = S_PAYLOAD;
                end
            end
`endif
            default: state_n = S_HUNT;
        endcase

        if (commit) begin
            if (word_cnt == 8'(FRAME_WORDS - 1)) begin
                frame_end_n = 1'b1;
                state_n     = S_HUNT;
                hunt_n      = '0;
                hunt_cnt_n  = '0;
                word_cnt_n  = '0;
            end else begin
                word_cnt_n = word_cnt + 1'b1;
            end
        end

        // Output register: a new word wins over an accept. A word completed
        // while the old one is still unaccepted is dropped.
        if (commit && (!dout_valid || dout_ready)) begin
            dout_n       = commit_word;
            dout_valid_n = 1'b1;
        end else begin
            if (commit)
                overflow_n = 1'b1;
            if (dout_valid && dout_ready)
                dout_valid_n = 1'b0;
        end
    end

endmodule
